coin_acceptor: RTL and testbench



---
 rtl/vending_pkg.sv | 23 ++
 rtl/coin_debounce.sv | 46 ++++
 rtl/coin_acceptor.sv | 152 +++++++++++++++
 tb/tb_coin_acceptor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared coin codes, coin values, emitter state encoding and a saturating adder
// for the coin intake path.
package vending_pkg;

  localparam logic COIN_10 = 1'b0;
  localparam logic COIN_50 = 1'b1;

  localparam int unsigned VAL_10 = 1;
  localparam int unsigned VAL_50 = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } emit_state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and a one-cycle
// event registered in the cycle the debounced level rises.
module coin_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_evt
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_deb;
  logic       r_evt;
  logic [7:0] r_cnt;

  // Flip the debounced level after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_evt   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_evt   <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == DEB_LAST) begin
        r_deb <= r_sync2;
        r_evt <= r_sync2;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/coin_acceptor.sv
// Coin intake: debounced sensors feed a small coin FIFO replayed as spaced
// credit/refund pulses. Optional credit tally under macro COIN_TALLY_EN.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_10_raw,
  input  logic       coin_50_raw,
  input  logic       accept_en,
`ifdef COIN_TALLY_EN
  input  logic       tally_clr,
  output logic [7:0] tally,
`endif
  output logic       dollar_10,
  output logic       dollar_50,
  output logic       coin_reject,
  output logic       coin_refund,
  output logic       busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic w_evt10;
  logic w_evt50;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
    .clk(clk), .reset(reset), .i_raw(coin_10_raw), .o_evt(w_evt10)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb50 (
    .clk(clk), .reset(reset), .i_raw(coin_50_raw), .o_evt(w_evt50)
  );

  logic             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_gap_cnt;
  emit_state_t      r_state;
  logic             r_dollar_10;
  logic             r_dollar_50;
  logic             r_reject;
  logic             r_refund;
  logic             r_busy;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_reject_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_busy_nxt;
  emit_state_t      w_state_nxt;
  logic             w_d10_nxt;
  logic             w_d50_nxt;
  logic             w_ref_nxt;

  // Intake: a lone event is queued when accepting and not full; all else rejects.
  assign w_full       = (r_count == FULL_CNT);
  assign w_push       = (w_evt10 ^ w_evt50) & accept_en & ~w_full;
  assign w_reject_nxt = (w_evt10 | w_evt50) & ~w_push;

  // Emitter next state; the pulse kind is decided in the pop cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_d10_nxt   = 1'b0;
    w_d50_nxt   = 1'b0;
    w_ref_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = EMIT;
          if (accept_en) begin
            w_d10_nxt = (r_mem[r_rd_ptr] == COIN_10);
            w_d50_nxt = (r_mem[r_rd_ptr] == COIN_50);
          end else begin
            w_ref_nxt = 1'b1;
          end
        end
      end
      EMIT:    w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (r_gap_cnt == GAP_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_busy_nxt  = (w_count_nxt != '0) || (w_state_nxt != IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt50 ? COIN_50 : COIN_10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_gap_cnt   <= 8'd0;
      r_dollar_10 <= 1'b0;
      r_dollar_50 <= 1'b0;
      r_reject    <= 1'b0;
      r_refund    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_gap_cnt   <= (r_state == GAP) ? r_gap_cnt + 8'd1 : 8'd0;
      r_dollar_10 <= w_d10_nxt;
      r_dollar_50 <= w_d50_nxt;
      r_reject    <= w_reject_nxt;
      r_refund    <= w_ref_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign dollar_10   = r_dollar_10;
  assign dollar_50   = r_dollar_50;
  assign coin_reject = r_reject;
  assign coin_refund = r_refund;
  assign busy        = r_busy;

`ifdef COIN_TALLY_EN
  logic [7:0] r_tally;

  // Credit total in NT10 units; clear beats a same-cycle credit.
  always_ff @(posedge clk) begin
    if (reset || tally_clr) r_tally <= 8'd0;
    else if (r_dollar_10)   r_tally <= sat_add8(r_tally, 8'(VAL_10));
    else if (r_dollar_50)   r_tally <= sat_add8(r_tally, 8'(VAL_50));
  end

  assign tally = r_tally;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: cycle table and hand sequences on two parameter sets,
// then random sensor traffic checked against a queue-level reference model.
module tb_coin_acceptor;

  localparam int unsigned DEB_F  = 1;
  localparam int unsigned GAP_F  = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int          RAND_N = 2000;
  localparam int          TBL_N  = 48;

  logic clk, reset;
  logic m_r10, m_r50, m_acc, m_d10, m_d50, m_rej, m_ref, m_busy;
  logic f_r10, f_r50, f_acc, f_d10, f_d50, f_rej, f_ref, f_busy;

  coin_acceptor #(.DEB_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .coin_10_raw(m_r10), .coin_50_raw(m_r50),
    .accept_en(m_acc), .dollar_10(m_d10), .dollar_50(m_d50),
    .coin_reject(m_rej), .coin_refund(m_ref), .busy(m_busy)
  );

  coin_acceptor #(.DEB_CYCLES(DEB_F), .GAP_CYCLES(GAP_F), .FIFO_DEPTH(DEPTH)) u_dut_f (
    .clk(clk), .reset(reset), .coin_10_raw(f_r10), .coin_50_raw(f_r50),
    .accept_en(f_acc), .dollar_10(f_d10), .dollar_50(f_d50),
    .coin_reject(f_rej), .coin_refund(f_ref), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r10, r50, acc;
    logic d10, d50, rej, rf, busy;
  } vec_t;

  vec_t tbl [TBL_N];
  int n_chk, n_err, lc;
  int m_d10_at[$], m_d50_at[$], m_rej_at[$], m_ref_at[$];
  int f_d10_at[$], f_d50_at[$], f_rej_at[$], f_ref_at[$];
  int none[$];

  // Reference model state for the random phase.
  bit h10 [RAND_N];
  bit h50 [RAND_N];
  bit mq[$];
  int m_ready;
  bit e_d10, e_d50, e_rej, e_ref, e_busy;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %p expected %p", name, got, exp);
    end
  endtask

  task automatic clear_rec();
    m_d10_at.delete(); m_d50_at.delete(); m_rej_at.delete(); m_ref_at.delete();
    f_d10_at.delete(); f_d50_at.delete(); f_rej_at.delete(); f_ref_at.delete();
    lc = 0;
  endtask

  // One cycle: sample at negedge, record pulse cycles, advance to posedge+1.
  task automatic step();
    @(negedge clk);
    if (m_d10) m_d10_at.push_back(lc);
    if (m_d50) m_d50_at.push_back(lc);
    if (m_rej) m_rej_at.push_back(lc);
    if (m_ref) m_ref_at.push_back(lc);
    if (f_d10) f_d10_at.push_back(lc);
    if (f_d50) f_d50_at.push_back(lc);
    if (f_rej) f_rej_at.push_back(lc);
    if (f_ref) f_ref_at.push_back(lc);
    chk("m_onehot", (int'(m_d10) + int'(m_d50) + int'(m_ref)) <= 1 ? 1 : 0, 1);
    chk("f_onehot", (int'(f_d10) + int'(f_d50) + int'(f_ref)) <= 1 ? 1 : 0, 1);
    @(posedge clk);
    #1;
    lc++;
  endtask

  // Clean sensors with DEB_F=1: debounced level is raw delayed by DEB_F+2 cycles.
  // Emitter: pops when idle and non-empty, pulses next cycle, idle again GAP_F+2 later.
  task automatic model_step(input int t, input bit acc);
    bit ev10, ev50, c;
    int sz0;
    ev10 = (t >= 3 && h10[t-3]) && !(t >= 4 && h10[t-4]);
    ev50 = (t >= 3 && h50[t-3]) && !(t >= 4 && h50[t-4]);
    sz0 = mq.size();
    e_d10 = 0; e_d50 = 0; e_rej = 0; e_ref = 0;
    if (t >= m_ready && sz0 > 0) begin
      c = mq.pop_front();
      if (!acc) e_ref = 1;
      else if (c) e_d50 = 1;
      else e_d10 = 1;
      m_ready = t + int'(GAP_F) + 2;
    end
    if (ev10 && ev50) e_rej = 1;
    else if (ev10 || ev50) begin
      if (acc && sz0 < int'(DEPTH)) mq.push_back(ev50);
      else e_rej = 1;
    end
    e_busy = (mq.size() > 0) || (t + 1 < m_ready);
  endtask

  initial begin
    n_chk = 0; n_err = 0; lc = 0;
    none = {};

    // Cycle table for the default-parameter instance (DEB=4, GAP=2).
    for (int i = 0; i < TBL_N; i++) begin
      tbl[i].r10 = (i <= 11) || (i >= 34 && i <= 41);
      tbl[i].r50 = (i >= 20 && i <= 27) || (i >= 34 && i <= 41);
      tbl[i].acc = !(i >= 12 && i <= 29);
      tbl[i].d10 = (i == 8);
      tbl[i].d50 = 1'b0;
      tbl[i].rej = (i == 27) || (i == 41);
      tbl[i].rf  = 1'b0;
      tbl[i].busy = (i >= 7 && i <= 10);
    end

    reset = 1'b1;
    m_r10 = 0; m_r50 = 0; m_acc = 0;
    f_r10 = 0; f_r50 = 0; f_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_d10", m_d10, 0);  chk("rst_m_d50", m_d50, 0);
    chk("rst_m_rej", m_rej, 0);  chk("rst_m_ref", m_ref, 0);
    chk("rst_m_busy", m_busy, 0);
    chk("rst_f_d10", f_d10, 0);  chk("rst_f_d50", f_d50, 0);
    chk("rst_f_rej", f_rej, 0);  chk("rst_f_ref", f_ref, 0);
    chk("rst_f_busy", f_busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < TBL_N; i++) begin
      m_r10 = tbl[i].r10; m_r50 = tbl[i].r50; m_acc = tbl[i].acc;
      @(negedge clk);
      chk($sformatf("tbl_d10@%0d", i), m_d10, tbl[i].d10);
      chk($sformatf("tbl_d50@%0d", i), m_d50, tbl[i].d50);
      chk($sformatf("tbl_rej@%0d", i), m_rej, tbl[i].rej);
      chk($sformatf("tbl_ref@%0d", i), m_ref, tbl[i].rf);
      chk($sformatf("tbl_busy@%0d", i), m_busy, tbl[i].busy);
      @(posedge clk);
      #1;
    end
    m_r10 = 0; m_r50 = 0; m_acc = 1;
    repeat (6) step();

    // NT50 bounce 1,0,1,0 then stable from cycle 4: one pulse at 4+DEB+4.
    clear_rec();
    for (int k = 0; k < 30; k++) begin
      m_r50 = (k < 4) ? (k % 2 == 0) : (k < 16);
      step();
    end
    chk_q("bounce_d50", m_d50_at, '{12});
    chk_q("bounce_d10", m_d10_at, none);
    chk_q("bounce_rej", m_rej_at, none);
    chk_q("bounce_ref", m_ref_at, none);
    chk("bounce_busy_end", m_busy, 0);

    // DEB=1/GAP=6 instance: seven NT10 coins, FIFO fills and the 7th is rejected.
    f_acc = 1;
    repeat (4) step();
    clear_rec();
    for (int k = 0; k < 55; k++) begin
      f_r10 = (k < 14) && (k % 2 == 0);
      step();
    end
    chk_q("full_d10", f_d10_at, '{5, 13, 21, 29, 37, 45});
    chk_q("full_rej", f_rej_at, '{16});
    chk_q("full_ref", f_ref_at, none);
    chk_q("full_d50", f_d50_at, none);

    // Coins queued behind a busy emitter drain as refunds once acceptance drops.
    clear_rec();
    for (int k = 0; k < 40; k++) begin
      f_r10 = (k < 8) && (k % 2 == 0);
      f_acc = (k < 10);
      step();
    end
    chk_q("refund_ref", f_ref_at, '{13, 21, 29});
    chk_q("refund_d10", f_d10_at, '{5});
    chk_q("refund_d50", f_d50_at, none);
    chk_q("refund_rej", f_rej_at, none);
    f_acc = 1;
    repeat (4) step();

    // Reset with two coins queued discards them silently.
    clear_rec();
    for (int k = 0; k < 30; k++) begin
      f_r10 = (k < 6) && (k % 2 == 0);
      reset = (k == 9) || (k == 10);
      step();
      if (lc == 8)  chk("rstq_busy_before", f_busy, 1);
      if (lc == 11) chk("rstq_busy_after", f_busy, 0);
    end
    chk_q("rstq_d10", f_d10_at, '{5});
    chk_q("rstq_ref", f_ref_at, none);
    chk_q("rstq_rej", f_rej_at, none);
    chk("rstq_busy_end", f_busy, 0);

    // Random sensor traffic on the DEB=1 instance against the reference model.
    f_r10 = 0; f_r50 = 0; f_acc = 1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mq.delete();
    m_ready = 0;
    e_d10 = 0; e_d50 = 0; e_rej = 0; e_ref = 0; e_busy = 0;
    for (int t = 0; t < RAND_N; t++) begin
      if ($urandom_range(5) == 0) f_r10 = ~f_r10;
      if ($urandom_range(5) == 0) f_r50 = ~f_r50;
      if ($urandom_range(24) == 0) f_acc = ~f_acc;
      h10[t] = f_r10;
      h50[t] = f_r50;
      @(negedge clk);
      chk($sformatf("rnd_d10@%0d", t), f_d10, int'(e_d10));
      chk($sformatf("rnd_d50@%0d", t), f_d50, int'(e_d50));
      chk($sformatf("rnd_rej@%0d", t), f_rej, int'(e_rej));
      chk($sformatf("rnd_ref@%0d", t), f_ref, int'(e_ref));
      chk($sformatf("rnd_busy@%0d", t), f_busy, int'(e_busy));
      model_step(t, f_acc);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
